// File: rtl/mux4_rr_sel_arbiter_pkg.sv
// mux4_rr_sel_arbiter_pkg: shared state encodings, sizes and one-hot helper for the mux4 arbiter
package mux4_rr_sel_arbiter_pkg;
   localparam int NUM_SRC = 4;
   localparam int IDX_W   = 2;
   typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
   function automatic logic [NUM_SRC-1:0] onehot(input logic [IDX_W-1:0] i);
      return NUM_SRC'(1) << i;
   endfunction
endpackage

// File: rtl/mux4_rr_sel_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin pick, first set bit of req&~mask searching upward from last_ptr+1
module rr_pick4
   import mux4_rr_sel_arbiter_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   input  logic [NUM_SRC-1:0] mask,
   input  logic [IDX_W-1:0]   last_ptr,
   output logic [IDX_W-1:0]   pick,
   output logic               pick_vld
);
   logic [NUM_SRC-1:0] r;
   logic [IDX_W-1:0]   c;
   assign r = req & ~mask;
   // descending scan: the last hit written is the closest one after last_ptr
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      c        = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         c = last_ptr + IDX_W'(k);
         if (r[c]) begin
            pick     = c;
            pick_vld = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mux4_rr_sel_arbiter.sv
// mux4_rr_sel_arbiter: round-robin arbiter with dwell preemption driving s1/s0 of a 4:1 mux
// Optional MUX4_ARB_LOCK_EN adds a lock input that suppresses dwell preemption.
module mux4_rr_sel_arbiter
   import mux4_rr_sel_arbiter_pkg::*;
#(
   parameter int DWELL_CYCLES = 8,
   parameter int CNT_W        = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] req,
`ifdef MUX4_ARB_LOCK_EN
   input  logic               lock,
`endif
   input  logic               done,
   output logic [NUM_SRC-1:0] gnt,
   output logic               gnt_valid,
   output logic               s1,
   output logic               s0
);
   localparam logic [CNT_W-1:0] CMAX = CNT_W'(DWELL_CYCLES - 1);
   state_t             st, st_nx;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   last_ptr, idx, pick;
   logic               pick_vld, granted, others, preempt, rel, load, no_lock;
`ifdef MUX4_ARB_LOCK_EN
   assign no_lock = ~lock;
`else
   assign no_lock = 1'b1;
`endif
   assign granted = st == ST_GRANT;
   assign others  = |(req & ~gnt);
   assign preempt = cnt == CMAX && others && no_lock;
   assign rel     = granted && (done || !req[idx] || preempt);
   assign load    = pick_vld && (!granted || rel);
   // while granted, search from the grantee so it falls to lowest priority
   rr_pick4 u_pick (
      .req      (req),
      .mask     (granted ? onehot(idx) : '0),
      .last_ptr (granted ? idx : last_ptr),
      .pick     (pick),
      .pick_vld (pick_vld)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= ST_IDLE;
         cnt      <= '0;
         last_ptr <= 2'd3;
         idx      <= '0;
      end else begin
         st       <= st_nx;
         cnt      <= (load || !granted) ? '0 : (cnt == CMAX ? cnt : cnt + 1'b1);
         last_ptr <= rel ? idx : last_ptr;
         idx      <= load ? pick : idx;
      end
   end
   always_comb begin
      st_nx = granted ? (rel ? (pick_vld ? ST_GRANT : ST_IDLE) : ST_GRANT) : (pick_vld ? ST_GRANT : ST_IDLE);
   end
   always_comb begin
      gnt       = granted ? onehot(idx) : '0;
      gnt_valid = granted;
      s1        = idx[1];
      s0        = idx[0];
   end
endmodule

// File: tb/tb_mux4_rr_sel_arbiter.sv
// tb_mux4_rr_sel_arbiter: directed scenarios plus randomized run against a behavioural owner/held model
module tb_mux4_rr_sel_arbiter;
   localparam int DWELL = 8;
   logic       clk = 1'b0;
   logic       rst, done;
   logic [3:0] req, gnt;
   logic       gnt_valid, s1, s0;
   int         checks = 0, passed = 0;
   int         owner, held, last;
   logic [1:0] sel;

   always #5 clk = ~clk;

   mux4_rr_sel_arbiter #(.DWELL_CYCLES(DWELL), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .gnt(gnt), .gnt_valid(gnt_valid), .s1(s1), .s0(s0)
   );

   function automatic int first_from(input logic [3:0] q, input int start);
      for (int k = 0; k < 4; k++)
         if (q[(start + k) % 4]) return (start + k) % 4;
      return -1;
   endfunction

   // owner = index holding the path (-1 idle), held = cycles it has held so far
   task automatic model_step(input logic r, input logic [3:0] q, input logic d);
      logic [3:0] oth;
      if (r) begin
         owner = -1; held = 0; last = 3; sel = 2'd0;
      end else if (owner < 0) begin
         if (q != 0) begin
            owner = first_from(q, last + 1); held = 1; sel = 2'(owner);
         end
      end else begin
         oth = q & ~(4'b0001 << owner);
         if (d || !q[owner] || (held >= DWELL && oth != 0)) begin
            last = owner;
            if (oth != 0) begin
               owner = first_from(oth, owner + 1); held = 1; sel = 2'(owner);
            end else owner = -1;
         end else held++;
      end
   endtask

   function automatic logic [6:0] expv();
      logic [3:0] g;
      g = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
      return {g, owner >= 0, sel};
   endfunction

   task automatic step(input logic r, input logic [3:0] q, input logic d);
      rst = r; req = q; done = d;
      model_step(r, q, d);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 4'b1111, 1'b0);
         checks++;
         if ({gnt, gnt_valid, s1, s0} !== 7'b0000_0_00)
            $display("FAIL reset: gnt/v/sel=%b want 0000_0_00", {gnt, gnt_valid, s1, s0});
         else passed++;
      end
   endtask

   task automatic test_single_done();
      step(1'b0, 4'b0100, 1'b0);
      checks++;
      if ({gnt, gnt_valid, s1, s0} !== 7'b0100_1_10)
         $display("FAIL single_grant: gnt/v/sel=%b want 0100_1_10", {gnt, gnt_valid, s1, s0});
      else passed++;
      step(1'b0, 4'b0100, 1'b1);
      checks++;
      if ({gnt, gnt_valid, s1, s0} !== 7'b0000_0_10)
         $display("FAIL done_release: gnt/v/sel=%b want 0000_0_10 (sel holds)", {gnt, gnt_valid, s1, s0});
      else passed++;
   endtask

   task automatic test_rotation();
      logic [3:0] want;
      step(1'b1, 4'b0000, 1'b0);
      for (int k = 0; k < 5 * DWELL; k++) begin
         step(1'b0, 4'b1111, 1'b0);
         want = 4'b0001 << ((k / DWELL) % 4);
         checks++;
         if (gnt !== want || gnt_valid !== 1'b1)
            $display("FAIL rotation cyc %0d: gnt=%b v=%b want %b v=1", k, gnt, gnt_valid, want);
         else passed++;
      end
   endtask

   task automatic test_lone_preempt();
      step(1'b1, 4'b0000, 1'b0);
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 4'b0001, 1'b0);
         checks++;
         if (gnt !== 4'b0001)
            $display("FAIL lone cyc %0d: gnt=%b want 0001", k, gnt);
         else passed++;
      end
      step(1'b0, 4'b0101, 1'b0);
      checks++;
      if ({gnt, s1, s0} !== 6'b0100_10)
         $display("FAIL preempt: gnt/sel=%b want 0100_10", {gnt, s1, s0});
      else passed++;
   endtask

   task automatic test_drop();
      step(1'b1, 4'b0000, 1'b0);
      step(1'b0, 4'b0010, 1'b0);
      step(1'b0, 4'b1001, 1'b0);
      checks++;
      if ({gnt, gnt_valid, s1, s0} !== 7'b1000_1_11)
         $display("FAIL drop_wrap: gnt/v/sel=%b want 1000_1_11", {gnt, gnt_valid, s1, s0});
      else passed++;
   endtask

   task automatic test_reset_mid();
      step(1'b1, 4'b0000, 1'b0);
      step(1'b0, 4'b0010, 1'b0);
      step(1'b1, 4'b0010, 1'b0);
      checks++;
      if ({gnt, gnt_valid, s1, s0} !== 7'b0000_0_00)
         $display("FAIL reset_mid: gnt/v/sel=%b want 0000_0_00", {gnt, gnt_valid, s1, s0});
      else passed++;
      step(1'b0, 4'b1111, 1'b0);
      checks++;
      if (gnt !== 4'b0001)
         $display("FAIL post_reset_first: gnt=%b want 0001", gnt);
      else passed++;
   endtask

   task automatic test_random();
      logic [3:0] q = 4'b0000;
      step(1'b1, 4'b0000, 1'b0);
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
         step($urandom_range(0, 99) == 0, q, $urandom_range(0, 9) == 0);
         checks++;
         if ({gnt, gnt_valid, s1, s0} !== expv())
            $display("FAIL random cyc %0d: gnt/v/sel=%b want %b", k, {gnt, gnt_valid, s1, s0}, expv());
         else passed++;
      end
   endtask

   initial begin
      rst = 1'b1; req = 4'b0000; done = 1'b0;
      owner = -1; held = 0; last = 3; sel = 2'd0;
      test_reset();
      test_single_done();
      test_rotation();
      test_lone_preempt();
      test_drop();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
